// File: rtl/fetch_pkg.sv
// Shared types for the fetch/prefetch unit: FSM states, queue entry layout
// and the PC step between consecutive instructions.
package fetch_pkg;

  localparam int FETCH_AD_LEN     = 32;
  localparam int FETCH_INST_WIDTH = 32;
  localparam logic [FETCH_AD_LEN-1:0] FETCH_PC_STEP = FETCH_AD_LEN'(FETCH_INST_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_AD_LEN-1:0]     pc;
    logic [FETCH_INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with push/pop/clear; simultaneous push and
// pop is accepted even when full. Storage resets to zero so the head reads 0.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  fetch_entry_t           data_i,
  output fetch_entry_t           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, empty_s, do_push_s, do_pop_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_s   = (count_q == {CW{1'b0}});
  assign do_pop_s  = pop_i & ~empty_s;
  assign do_push_s = push_i & (~full_s | do_pop_s);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is 2^PW
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + PW'(1'b1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + PW'(1'b1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_s && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty_s;

endmodule

// File: rtl/fetch_prefetch.sv
// Decoupled fetch unit: one outstanding req/ack read at a time, prefetch queue
// of {pc, inst}, redirect flush. `define FETCH_PERF_EN adds pop/discard counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int                AD_LEN     = FETCH_AD_LEN,
  parameter int                BUS_WIDTH  = 32,
  parameter int                INST_WIDTH = FETCH_INST_WIDTH,
  parameter int                DEPTH      = 4,
  parameter logic [AD_LEN-1:0] RESET_PC   = {AD_LEN{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  redirect_i,
  input  logic [AD_LEN-1:0]     redirect_pc_i,
  output logic                  bus_req_o,
  output logic [AD_LEN-1:0]     bus_ad_o,
  input  logic                  bus_ack_i,
  input  logic [BUS_WIDTH-1:0]  bus_data_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [AD_LEN-1:0]     inst_pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_count_o,
  output logic [31:0]           flush_count_o
`endif
);

  localparam int                CW      = $clog2(DEPTH) + 1;
  localparam logic [AD_LEN-1:0] PC_STEP = AD_LEN'(INST_WIDTH / 8);

  fetch_state_e      state_q, state_d;
  logic [AD_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [AD_LEN-1:0] bus_ad_q, bus_ad_d;
  logic              bus_req_q, bus_req_d;
  logic              push_s, pop_s, empty_s, full_s;
  logic [CW-1:0]     count_s;
  fetch_entry_t      entry_s, head_s;

  assign entry_s.pc   = fetch_pc_q;
  assign entry_s.inst = bus_data_i[INST_WIDTH-1:0];
  assign full_s       = (count_s == CW'(DEPTH));
  assign pop_s        = ~empty_s & inst_ready_i & ~redirect_i;

  // Fetch FSM: a request only starts with a free queue slot, so its ack always fits
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    bus_ad_d   = bus_ad_q;
    bus_req_d  = 1'b0;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
          bus_ad_d   = redirect_pc_i;
          state_d    = REQ;
        end else if (!full_s) begin
          bus_ad_d = fetch_pc_q;
          state_d  = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
          if (bus_ack_i) state_d = IDLE;
          else           state_d = FLUSH;
        end else if (bus_ack_i) begin
          push_s     = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      FLUSH: begin
        if (redirect_i) fetch_pc_d = redirect_pc_i;
        else            fetch_pc_d = fetch_pc_q;
        if (bus_ack_i) state_d = IDLE;
        else           state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase
    bus_req_d = (state_d != IDLE);
  end

  // FSM and bus-side registers
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      bus_req_q  <= 1'b0;
      bus_ad_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bus_req_q  <= bus_req_d;
      bus_ad_q   <= bus_ad_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .clear_i  (redirect_i),
    .data_i   (entry_s),
    .data_o   (head_s),
    .count_o  (count_s),
    .empty_o  (empty_s)
  );

  assign bus_req_o    = bus_req_q;
  assign bus_ad_o     = bus_ad_q;
  assign inst_valid_o = ~empty_s;
  assign inst_o       = head_s.inst;
  assign inst_pc_o    = head_s.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, flush_count_q;
  logic        discard_s;

  assign discard_s = bus_ack_i & ((state_q == FLUSH) | ((state_q == REQ) & redirect_i));

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      fetch_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      if (pop_s)     fetch_count_q <= fetch_count_q + 32'd1;
      if (discard_s) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign flush_count_o = flush_count_q;
`endif

endmodule
